// File: rtl/rf_wb_queue.sv
// Register-file write-back queue.
// Holds pending {addr, data} write-backs in order and drains them into the
// register file whenever it grants a write slot. It also exposes combinational
// forwarding of pending data to two operand read ports.
module rf_wb_queue #(
    parameter int DW    = 21,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    input  logic [AW-1:0]            rd_addr_a,
    input  logic [AW-1:0]            rd_addr_b,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic [DW-1:0]            fwd_data_a,
    output logic [DW-1:0]            fwd_data_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    // Handshake and drain decisions. in_ready ignores a same-cycle pop on
    // purpose, so a full queue never accepts a push on the edge that drains it.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        in_ready = !full;
        wr_en    = drain_en && !empty;
        push     = in_valid && in_ready;
        pop      = wr_en;
        wr_addr  = wr_en ? addr_mem[head] : '0;
        wr_data  = wr_en ? data_mem[head] : '0;
    end

    // Pointer and occupancy bookkeeping. Reset wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage. Validity comes from head/count, so the payload needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

    // Forwarding: scan from oldest to youngest so the youngest match wins.
    // Only queued entries are considered, never the request on in_addr/in_data.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (addr_mem[idx] == rd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = data_mem[idx];
                end
                if (addr_mem[idx] == rd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = data_mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Testbench for rf_wb_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_rf_wb_queue;

    localparam int DW    = 21;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          fwd_hit_a;
    logic          fwd_hit_b;
    logic [DW-1:0] fwd_data_a;
    logic [DW-1:0] fwd_data_b;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int tests = 0;
    int fails = 0;

    // Reference model: queues of pending addresses and data, oldest first.
    logic [AW-1:0] qa [$];
    logic [DW-1:0] qd [$];

    rf_wb_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .drain_en   (drain_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .fwd_hit_a  (fwd_hit_a),
        .fwd_hit_b  (fwd_hit_b),
        .fwd_data_a (fwd_data_a),
        .fwd_data_b (fwd_data_b),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending entry for an address: search from the tail backwards.
    task automatic model_fwd(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = qa.size() - 1; i >= 0; i--) begin
            if (qa[i] == ra) begin
                hit = 1'b1;
                d   = qd[i];
                break;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int            sz;
        logic          exp_wr;
        logic          h;
        logic [DW-1:0] d;
        sz     = qa.size();
        exp_wr = drain_en && (sz > 0);
        check({tag, "_count"}, count, sz);
        check({tag, "_empty"}, empty, sz == 0);
        check({tag, "_full"}, full, sz == DEPTH);
        check({tag, "_in_ready"}, in_ready, sz < DEPTH);
        check({tag, "_wr_en"}, wr_en, exp_wr);
        check({tag, "_wr_addr"}, wr_addr, exp_wr ? qa[0] : '0);
        check({tag, "_wr_data"}, wr_data, exp_wr ? qd[0] : '0);
        model_fwd(rd_addr_a, h, d);
        check({tag, "_fwd_hit_a"}, fwd_hit_a, h);
        check({tag, "_fwd_data_a"}, fwd_data_a, d);
        model_fwd(rd_addr_b, h, d);
        check({tag, "_fwd_hit_b"}, fwd_hit_b, h);
        check({tag, "_fwd_data_b"}, fwd_data_b, d);
    endtask

    // One clock: optionally check outputs for the current inputs, then apply
    // the edge to the model and return at the next falling edge.
    task automatic cycle(input bit chk, input string tag);
        int sz;
        #1;
        if (chk) check_all(tag);
        @(posedge clk);
        sz = qa.size();
        if (rst) begin
            qa.delete();
            qd.delete();
        end else begin
            if (drain_en && sz > 0) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (in_valid && sz < DEPTH) begin
                qa.push_back(in_addr);
                qd.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        drain_en  = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
    endtask

    task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        logic [AW-1:0] ord_a [$];
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        cycle(0, "pre");
        cycle(1, "rst_hold");
        rst = 1'b0;

        // Reset state.
        #1;
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_fwd_hit_a", fwd_hit_a, 1'b0);

        // Single push, then drain.
        push_req(3'd3, 21'h1ABCD);
        cycle(1, "s1_push");
        check("s1_count", count, 1);
        in_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        check("s1_wr_en", wr_en, 1'b1);
        check("s1_wr_addr", wr_addr, 3'd3);
        check("s1_wr_data", wr_data, 21'h1ABCD);
        cycle(1, "s1_drain");
        check("s1_count_after", count, 0);

        // Fill to full; a fifth request waits until a pop frees a slot.
        drain_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_req(AW'(i + 1), DW'(21'h00100 + i));
            cycle(1, "s2_fill");
        end
        check("s2_full", full, 1'b1);
        check("s2_in_ready", in_ready, 1'b0);
        push_req(3'd7, 21'h0FFFF);
        cycle(1, "s2_blocked");
        check("s2_still_full", count, DEPTH);
        drain_en = 1'b1;
        cycle(1, "s2_pop_no_push");
        check("s2_count_after_pop", count, DEPTH - 1);
        check("s2_in_ready_after_pop", in_ready, 1'b1);
        drain_en = 1'b0;
        cycle(1, "s2_accept");
        check("s2_fifth_accepted", count, DEPTH);

        // Forwarding picks the youngest match; no coalescing.
        rst = 1'b1;
        idle_inputs();
        cycle(1, "s3_rst");
        rst = 1'b0;
        push_req(3'd2, 21'h00011);
        cycle(1, "s3_p1");
        push_req(3'd2, 21'h00022);
        cycle(1, "s3_p2");
        in_valid  = 1'b0;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd5;
        #1;
        check("s3_fwd_hit_a", fwd_hit_a, 1'b1);
        check("s3_fwd_data_a", fwd_data_a, 21'h00022);
        check("s3_fwd_hit_b", fwd_hit_b, 1'b0);
        check("s3_fwd_data_b", fwd_data_b, 21'h0);
        drain_en = 1'b1;
        cycle(1, "s3_d1");
        check("s3_second_wr_data", wr_data, 21'h00022);
        cycle(1, "s3_d2");

        // No bypass on an empty queue.
        push_req(3'd6, 21'h0BEEF);
        #1;
        check("s4_no_bypass", wr_en, 1'b0);
        cycle(1, "s4_push");
        in_valid = 1'b0;
        #1;
        check("s4_next_wr_en", wr_en, 1'b1);
        check("s4_next_wr_data", wr_data, 21'h0BEEF);
        cycle(1, "s4_drain");

        // Steady state at count=2 with simultaneous push/pop; pointers wrap.
        drain_en = 1'b0;
        push_req(3'd0, 21'h00500);
        cycle(1, "s5_pre0");
        push_req(3'd1, 21'h00501);
        cycle(1, "s5_pre1");
        ord_a.delete();
        ord_a.push_back(3'd0);
        ord_a.push_back(3'd1);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_req(AW'(i + 2), DW'(21'h00502 + i));
            #1;
            check("s5_order", wr_addr, ord_a.pop_front());
            ord_a.push_back(in_addr);
            cycle(1, "s5_steady");
            check("s5_count", count, 2);
        end

        // Reset with pending entries and an offered request drops everything.
        drain_en = 1'b0;
        push_req(3'd4, 21'h00700);
        cycle(1, "s6_fill");
        check("s6_count3", count, 3);
        rst = 1'b1;
        push_req(3'd5, 21'h00777);
        drain_en = 1'b1;
        cycle(0, "s6_rst");
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("s6_count0", count, 0);
        check("s6_empty", empty, 1'b1);
        check("s6_wr_en", wr_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, "s6_quiet");
            check("s6_no_write", wr_en, 1'b0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_addr   = AW'($urandom);
            in_data   = DW'($urandom);
            drain_en  = ($urandom_range(0, 2) != 0);
            rd_addr_a = AW'($urandom);
            rd_addr_b = AW'($urandom);
            cycle(1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 The block SHALL have parameter DW, default 21, meaning the register data width.
REQ-002 The block SHALL have parameter AW, default 3, meaning the register address width (8 registers).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  a write-back request is presented.
REQ-007 in_ready  output  1  the queue can accept a request this cycle.
REQ-008 in_addr  input  AW  destination register of the request.
REQ-009 in_data  input  DW  write-back data of the request.
REQ-010 drain_en  input  1  the register file permits a write this cycle.
REQ-011 wr_en  output  1  register-file write enable (feeds the enable-decoder En).
REQ-012 wr_addr  output  AW  register-file write address.
REQ-013 wr_data  output  DW  register-file write data (feeds the parallel-load register inputs).
REQ-014 rd_addr_a, rd_addr_b  input  AW each  operand read addresses to check for forwarding.
REQ-015 fwd_hit_a, fwd_hit_b  output  1 each  a pending queue entry targets the read address.
REQ-016 fwd_data_a, fwd_data_b  output  DW each  forwarded data.
REQ-017 count  output  clog2(DEPTH)+1  number of valid entries; empty and full  output  1 each.

Function
REQ-018 The block SHALL hold an in-order FIFO of {addr, data} entries, with head/tail pointers wrapping modulo DEPTH.
REQ-019 A push SHALL occur at a rising edge when in_valid=1 and in_ready=1; the entry is written at the tail.
REQ-020 in_ready SHALL equal !full combinationally; a simultaneous pop SHALL NOT make room for a push in the same cycle.
REQ-021 wr_en SHALL equal drain_en AND !empty combinationally; when wr_en=1, wr_addr/wr_data SHALL equal the head entry.
REQ-022 When wr_en=0, wr_addr and wr_data SHALL be driven to zero.
REQ-023 A pop SHALL occur at every rising edge where wr_en=1; the register file captures the same edge, so data is never lost or duplicated.
REQ-024 There SHALL be no bypass: an entry pushed at edge N reaches wr_en no earlier than the cycle after edge N, even if the queue was empty and drain_en=1.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push only increments count by 1; pop only decrements it by 1.
REQ-026 Pop when empty and push when full SHALL be impossible by construction; count SHALL stay within 0..DEPTH.
REQ-027 fwd_hit_x SHALL be 1 when any valid entry has addr == rd_addr_x, including the head entry being popped this cycle.
REQ-028 fwd_data_x SHALL be the data of the youngest matching entry (closest to the tail); if fwd_hit_x=0, it is zero.
REQ-029 Forwarding SHALL be purely combinational and SHALL NOT consider in_addr/in_data of a request not yet pushed.
REQ-030 Multiple entries to the same address SHALL be retained and written in order (no coalescing).
REQ-031 empty SHALL be (count==0); full SHALL be (count==DEPTH).

Reset
REQ-032 While rst=1 at a rising edge, pointers and count SHALL clear, and all entries SHALL become invalid; the next cycle shows empty=1, full=0, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, and fwd_hit_a=fwd_hit_b=0.
REQ-033 rst SHALL take priority over push and pop in the same cycle; a request offered during reset is discarded, and a pending entry is dropped without being written.

Verification
REQ-034 After reset, push (addr 3, 0x1ABCD) with drain_en=0 -> count=1; drain_en=1 next cycle -> wr_en=1, wr_addr=3, wr_data=0x1ABCD; count=0 after the edge.
REQ-035 Push 4 entries with drain_en=0 -> full=1, in_ready=0; a 5th in_valid is not accepted; hold in_valid with drain_en=1 -> the pop frees a slot and the 5th entry is accepted on the following edge.
REQ-036 Queue holds (2, 0x00011) then (2, 0x00022); rd_addr_a=2 -> fwd_hit_a=1, fwd_data_a=0x00022; rd_addr_b=5 -> fwd_hit_b=0, fwd_data_b=0.
REQ-037 Empty queue with drain_en=1 and a push -> wr_en=0 in the push cycle, then wr_en=1 in the next cycle.
REQ-038 With count=2, push and pop on the same edge for 10 cycles -> count stays 2, pointers wrap, and writes emerge in push order.
REQ-039 Assert rst with count=3 and in_valid=1 -> the next cycle shows count=0, empty=1, wr_en=0, and no further writes occur.
